ysyx_23060208_ifu_prefetch: RTL

YSYX_23060208_IFU_PREFETCH -- requirements
Module: ysyx_23060208_ifu_prefetch

---
 rtl/ysyx_23060208_ifu_prefetch.sv | 112 +++++++++++
 1 files changed

// File: rtl/ysyx_23060208_ifu_prefetch.sv
// ysyx_23060208_ifu_prefetch: instruction prefetcher feeding a small FIFO from an AXI-lite-style read port
// Ports: clk/rst (async active-high); redirect_valid/redirect_pc restart fetch;
// isram_ar*/isram_r* read channel (one outstanding read); out_* head entry to IDU;
// fifo_count is the buffer occupancy.
module ysyx_23060208_ifu_prefetch #(
    parameter int DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h8000_0000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          redirect_valid,
    input  logic [DATA_WIDTH-1:0]         redirect_pc,
    output logic [DATA_WIDTH-1:0]         isram_araddr,
    output logic                          isram_arvalid,
    input  logic                          isram_arready,
    input  logic [DATA_WIDTH-1:0]         isram_rdata,
    input  logic                          isram_rvalid,
    input  logic [1:0]                    isram_rresp,
    output logic                          isram_rready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_pc,
    output logic [DATA_WIDTH-1:0]         out_inst,
    output logic                          out_fault,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] AR   = 2'd1;
    localparam logic [1:0] R    = 2'd2;
    localparam logic [1:0] HALT = 2'd3;

    logic [1:0]            state, state_nx;
    logic                  squash, squash_nx;
    logic [DATA_WIDTH-1:0] fetch_pc, req_pc;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] pc_q   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] inst_q [FIFO_DEPTH];
    logic                  fault_q[FIFO_DEPTH];
    logic                  ar_hs, r_hs, fault, push, pop, issue;

    assign ar_hs = isram_arvalid & isram_arready;
    assign r_hs  = isram_rready & isram_rvalid;
    assign fault = |isram_rresp;
    // a response is kept only if it is not stale and no redirect lands in the same cycle
    assign push  = r_hs & ~squash & ~redirect_valid;
    assign pop   = out_valid & out_ready & ~redirect_valid;
    assign issue = (state == IDLE) & (count != CW'(FIFO_DEPTH)) & ~redirect_valid;

    always_comb begin
        state_nx = state == IDLE ? (issue ? AR : IDLE) :
                   state == AR   ? (ar_hs ? R : AR) :
                   state == R    ? (!r_hs ? R : (push && fault) ? HALT : IDLE) :
                                   (redirect_valid ? IDLE : HALT);
        // arvalid cannot be withdrawn, so an in-flight read is tracked and dropped later
        squash_nx = (redirect_valid && (state == AR || (state == R && !r_hs))) ? 1'b1 :
                    r_hs ? 1'b0 : squash;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            squash   <= 1'b0;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state  <= state_nx;
            squash <= squash_nx;
            // araddr comes from req_pc so a redirect cannot disturb a pending request
            if (issue)
                req_pc <= fetch_pc;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                if (push) begin
                    fetch_pc <= fetch_pc + DATA_WIDTH'(4);
                    wr_ptr   <= wr_ptr + AW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]    <= req_pc;
            inst_q[wr_ptr]  <= isram_rdata;
            fault_q[wr_ptr] <= fault;
        end
    end

    assign isram_arvalid = state == AR;
    assign isram_araddr  = req_pc;
    assign isram_rready  = state == R;
    assign fifo_count    = count;
    assign out_valid     = count != '0;
    // head fields are masked so they read 0 when empty or in reset
    assign out_pc        = out_valid ? pc_q[rd_ptr] : '0;
    assign out_inst      = out_valid ? inst_q[rd_ptr] : '0;
    assign out_fault     = out_valid & fault_q[rd_ptr];
endmodule
